// File: rtl/macc_result_drain.sv
// macc_result_drain: sequences one MACC kernel (start -> taps -> pipeline
// latency), then samples the accumulator, requantizes it with
// round-half-up and saturation, and queues it in a small first-word-fall-
// through FIFO for the consumer.
// Optional feature: define MACC_DRAIN_RELU_EN to clamp negative results
// to zero before they are queued; timing and handshakes are unaffected.
module macc_result_drain #(
    parameter int SIZEIN     = 16,
    parameter int SIZEOUT    = 40,
    parameter int FRAC_SHIFT = 8,
    parameter int LATENCY    = 3,
    parameter int KLEN_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [KLEN_W-1:0]         kernel_len,
    input  logic                      tap_valid,
    input  logic signed [SIZEOUT-1:0] accum_in,
    output logic signed [SIZEIN-1:0]  out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow
);

    localparam int LAT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    // Rounding constant 2^(FRAC_SHIFT-1) at the widened sum width.
    localparam logic signed [SIZEOUT:0] RND =
        {{SIZEOUT{1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
    localparam logic signed [SIZEOUT:0] SAT_MAX =
        {{(SIZEOUT - SIZEIN + 2){1'b0}}, {(SIZEIN - 1){1'b1}}};
    localparam logic signed [SIZEOUT:0] SAT_MIN =
        {{(SIZEOUT - SIZEIN + 2){1'b1}}, {(SIZEIN - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        WAIT
    } state_t;

    state_t                   state;
    logic [KLEN_W-1:0]        klen;
    logic [KLEN_W-1:0]        tap_cnt;
    logic [LAT_W-1:0]         lat_cnt;

    logic signed [SIZEIN-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         count;

    logic                     capture;
    logic                     start_acc;
    logic                     full;
    logic                     pop;
    logic                     accept;
    logic                     drop;
    logic signed [SIZEIN-1:0] push_data;

    // Add the half-LSB at one extra bit so the largest accumulator cannot
    // wrap, then arithmetic-shift: this rounds halves toward +inf.
    function automatic logic signed [SIZEOUT:0] round_shift(
        input logic signed [SIZEOUT-1:0] a
    );
        logic signed [SIZEOUT:0] sum;
        sum = $signed({a[SIZEOUT-1], a}) + RND;
        return sum >>> FRAC_SHIFT;
    endfunction

    // Clamp the widened value into the signed output range.
    function automatic logic signed [SIZEIN-1:0] saturate(
        input logic signed [SIZEOUT:0] v
    );
        if (v > SAT_MAX) begin
            return SAT_MAX[SIZEIN-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[SIZEIN-1:0];
        end else begin
            return v[SIZEIN-1:0];
        end
    endfunction

    // Optional rectification of the already-saturated result.
    function automatic logic signed [SIZEIN-1:0] relu(
        input logic signed [SIZEIN-1:0] v
    );
`ifdef MACC_DRAIN_RELU_EN
        return v[SIZEIN-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // The latency counter counts LATENCY..0; the zero cycle is the one after
    // it held 1, so the final tap at edge T is followed by a sample at
    // edge T+LATENCY+1.
    assign capture   = (state == WAIT) && (lat_cnt == '0);
    assign start_acc = (state == IDLE) && start;
    assign push_data = relu(saturate(round_shift(accum_in)));

    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign busy      = (state != IDLE);

    assign full   = (count == CNT_W'(FIFO_DEPTH));
    assign pop    = out_valid && out_ready;
    assign accept = capture && (!full || pop);
    assign drop   = capture && full && !pop;

    // Kernel sequencer: latch length, count taps, wait out the MACC latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            klen    <= '0;
            tap_cnt <= '0;
            lat_cnt <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        klen    <= (kernel_len == '0) ? KLEN_W'(1) : kernel_len;
                        tap_cnt <= '0;
                        state   <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (tap_valid) begin
                        tap_cnt <= tap_cnt + KLEN_W'(1);
                        if ((tap_cnt + KLEN_W'(1)) == klen) begin
                            lat_cnt <= LAT_W'(LATENCY);
                            state   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO control: pointers, occupancy and the sticky overflow flag. A push
    // into a full FIFO is still taken when the head is popped the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (start_acc) begin
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // FIFO storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: tb/tb_macc_result_drain.sv
// Directed bench for macc_result_drain: a table of single-kernel
// requantization vectors plus hand-written sequences for gaps, overflow,
// full-with-pop and mid-kernel reset.
module tb_macc_result_drain;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [9:0]         kernel_len;
    logic               tap_valid;
    logic signed [39:0] accum_in;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic               done;
    logic               overflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    macc_result_drain dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .kernel_len (kernel_len),
        .tap_valid  (tap_valid),
        .accum_in   (accum_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    typedef struct {
        logic [9:0]         len;
        logic signed [39:0] acc;
        int                 expv;
    } vec_t;

    vec_t vecs[14];

    function automatic int model_out(input int v);
`ifdef MACC_DRAIN_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_kernel(input string name, input logic [9:0] len,
                              input logic signed [39:0] acc, input bit pop_cap);
        int  ntaps;
        int  w;
        bit  got;
        ntaps      = (len == 0) ? 1 : int'(len);
        start      = 1'b1;
        kernel_len = len;
        tick();
        start      = 1'b0;
        kernel_len = '0;
        chk({name, " busy"}, busy, 1);
        chk({name, " ovf_clear"}, overflow, 0);
        for (int i = 0; i < ntaps; i++) begin
            tap_valid = 1'b1;
            tick();
        end
        tap_valid = 1'b0;
        accum_in  = acc;
        got = 1'b0;
        w   = 0;
        while (!got && w < 20) begin
            w++;
            if (pop_cap && w == 4) out_ready = 1'b1;
            tick();
            if (pop_cap) out_ready = 1'b0;
            if (done) got = 1'b1;
        end
        chk({name, " done_lat"}, w, 4);
        chk({name, " busy_end"}, busy, 0);
        tick();
        chk({name, " done_pulse"}, done, 0);
    endtask

    task automatic pop_check(input string name, input int expv);
        chk({name, " valid"}, out_valid, 1);
        chk({name, " data"}, out_data, model_out(expv));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        int dcount;

        vecs[0]  = '{10'd3, 40'sd384, 2};
        vecs[1]  = '{10'd3, -40'sd384, -1};
        vecs[2]  = '{10'd1, 40'sd1073741824, 32767};
        vecs[3]  = '{10'd2, -40'sd1073741824, -32768};
        vecs[4]  = '{10'd0, 40'sd127, 0};
        vecs[5]  = '{10'd1, 40'sd128, 1};
        vecs[6]  = '{10'd4, -40'sd128, 0};
        vecs[7]  = '{10'd1, -40'sd129, -1};
        vecs[8]  = '{10'd2, 40'sd8388479, 32767};
        vecs[9]  = '{10'd1, 40'sd8388480, 32767};
        vecs[10] = '{10'd1, -40'sd8388608, -32768};
        vecs[11] = '{10'd1, -40'sd8388737, -32768};
        vecs[12] = '{10'd5, 40'sh7F_FFFF_FFFF, 32767};
        vecs[13] = '{10'd1, 40'sh80_0000_0000, -32768};

        rst        = 1'b1;
        start      = 1'b0;
        kernel_len = '0;
        tap_valid  = 1'b0;
        accum_in   = '0;
        out_ready  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst out_valid", out_valid, 0);
        chk("rst out_data", out_data, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst overflow", overflow, 0);

        // Table of single kernels, each result popped immediately.
        for (int i = 0; i < 14; i++) begin
            run_kernel($sformatf("vec%0d", i), vecs[i].len, vecs[i].acc, 1'b0);
            pop_check($sformatf("vec%0d", i), vecs[i].expv);
            chk($sformatf("vec%0d empty", i), out_valid, 0);
        end

        // Taps in IDLE are ignored.
        tap_valid = 1'b1;
        tick();
        tick();
        tap_valid = 1'b0;
        chk("idle taps busy", busy, 0);
        chk("idle taps valid", out_valid, 0);

        // Spread taps; start/taps during WAIT and start on the return cycle.
        start      = 1'b1;
        kernel_len = 10'd3;
        tick();
        start      = 1'b0;
        tap_valid  = 1'b1; tick();
        tap_valid  = 1'b0; tick();
        tap_valid  = 1'b1; tick();
        tap_valid  = 1'b0; tick(); tick();
        chk("gap busy mid", busy, 1);
        tap_valid  = 1'b1; tick();
        tap_valid  = 1'b0;
        accum_in   = 40'sd1892;
        w = 0;
        while (!done && w < 20) begin
            w++;
            start      = (w == 2 || w == 4);
            kernel_len = 10'd1;
            tap_valid  = (w == 2);
            tick();
            start     = 1'b0;
            tap_valid = 1'b0;
        end
        chk("gap done_lat", w, 4);
        chk("gap busy_end", busy, 0);
        tick();
        chk("gap start_on_return", busy, 0);
        tick();
        chk("gap start_in_wait", busy, 0);
        pop_check("gap", 7);
        chk("gap empty", out_valid, 0);

        // Overflow: five kernels, nothing consumed.
        for (int k = 1; k <= 5; k++) begin
            run_kernel($sformatf("ovf%0d", k), 10'd1, 40'(256 * k), 1'b0);
            chk($sformatf("ovf%0d flag", k), overflow, (k == 5) ? 1 : 0);
        end
        for (int k = 1; k <= 4; k++) pop_check($sformatf("ovf drain%0d", k), k);
        chk("ovf drained", out_valid, 0);
        chk("ovf sticky", overflow, 1);

        // Full FIFO with a pop coinciding with the fifth push.
        for (int k = 10; k <= 13; k++)
            run_kernel($sformatf("sim%0d", k), 10'd2, 40'(256 * k), 1'b0);
        chk("sim head", out_data, model_out(10));
        run_kernel("sim14", 10'd1, 40'(256 * 14), 1'b1);
        chk("sim no_ovf", overflow, 0);
        for (int k = 11; k <= 14; k++) pop_check($sformatf("sim drain%0d", k), k);
        chk("sim drained", out_valid, 0);

        // Reset while waiting on the MACC pipeline.
        run_kernel("pre_rst", 10'd1, 40'sd768, 1'b0);
        start      = 1'b1;
        kernel_len = 10'd2;
        tick();
        start      = 1'b0;
        tap_valid  = 1'b1; tick(); tick();
        tap_valid  = 1'b0;
        tick(); tick();
        chk("rstw busy before", busy, 1);
        rst       = 1'b1;
        start     = 1'b1;
        tap_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        rst       = 1'b0;
        start     = 1'b0;
        tap_valid = 1'b0;
        out_ready = 1'b0;
        chk("rstw done", done, 0);
        chk("rstw out_valid", out_valid, 0);
        chk("rstw busy", busy, 0);
        chk("rstw out_data", out_data, 0);
        dcount = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) dcount++;
        end
        chk("rstw no_late_done", dcount, 0);
        chk("rstw still_empty", out_valid, 0);
        run_kernel("post_rst", 10'd3, 40'sd384, 1'b0);
        pop_check("post_rst", 2);
        chk("post_rst empty", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/macc_result_drain.md
MACC_RESULT_DRAIN -- requirements
Module: macc_result_drain

Interface
REQ-001 Parameters SHALL be, one per line:
- SIZEIN, 16: output sample width.
- SIZEOUT, 40: accumulator input width.
- FRAC_SHIFT, 8: right shift applied when requantizing; range 1..SIZEOUT-SIZEIN.
- LATENCY, 3: MACC cycles from last tap issue to a valid accumulator result.
- KLEN_W, 10: kernel_len width.
- FIFO_DEPTH, 4: output FIFO entries; power of two.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  single-cycle pulse; begins one kernel.
- kernel_len  in  KLEN_W  taps per kernel; sampled on the start cycle.
- tap_valid  in  1  one operand pair issued to the MACC this cycle.
- accum_in  in  SIZEOUT  signed accumulator result from the MACC.
- out_data  out  SIZEIN  signed requantized result (FIFO head).
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse on the cycle a result is captured.
- overflow  out  1  sticky; a result was dropped because the FIFO was full.

Function
REQ-003 The FSM SHALL have three states: IDLE, ACCUM, WAIT.
REQ-004 IDLE:
- start=1 latches kernel_len, clears the tap counter and moves to ACCUM.
- kernel_len=0 SHALL be treated as 1.
REQ-005 ACCUM:
- Each tap_valid=1 cycle increments the tap counter.
- The tap_valid that makes the count equal the latched length loads the latency counter with LATENCY and moves to WAIT.
REQ-006 WAIT:
- The latency counter decrements each cycle.
- In the cycle after it reaches 1, accum_in is sampled, requantized and pushed.
- done pulses for 1 cycle and the FSM returns to IDLE.
- Final tap at cycle T means accum_in is sampled at edge T+LATENCY+1.
REQ-007 tap_valid in IDLE or WAIT SHALL be ignored.
REQ-008 start outside IDLE SHALL be ignored.
REQ-009 start in the same cycle the FSM returns to IDLE SHALL be ignored; start is accepted from the following cycle.
REQ-010 Requantization: r = (accum_in + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT, an arithmetic shift giving round-half-toward-+inf. The sum SHALL be computed at SIZEOUT+1 bits with no wrap.
REQ-011 Saturation: r SHALL be clamped to [-2^(SIZEIN-1), 2^(SIZEIN-1)-1] before the push.
REQ-012 The FIFO SHALL be first-word-fall-through: out_data is valid whenever out_valid=1, and a pop occurs when out_valid and out_ready are both 1.
REQ-013 Push when full with a simultaneous pop SHALL be accepted; occupancy is unchanged.
REQ-014 Push when full without a pop SHALL drop the result and set overflow.
- done still pulses.
- FIFO contents are unchanged.
REQ-015 overflow SHALL clear on rst or on an accepted start.
REQ-016 Push and pop on an empty FIFO SHALL NOT bypass: out_valid rises the cycle after the push.
REQ-017 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with a separate occupancy count of 0..FIFO_DEPTH.

Reset
REQ-018 On rst=1 at a clock edge, the block SHALL reset to:
- FSM in IDLE; tap and latency counters 0; FIFO emptied.
- out_valid=0, out_data=0, busy=0, done=0, overflow=0.
REQ-019 rst SHALL override start, tap_valid and out_ready in the same cycle.
REQ-020 rst mid-kernel SHALL abandon the kernel with no push and no done pulse.

Configuration
REQ-021 With macro MACC_DRAIN_RELU_EN defined, a negative saturated result SHALL be replaced by 0 before the push.
REQ-022 Without MACC_DRAIN_RELU_EN, signed results SHALL be pushed unchanged.
REQ-023 The macro SHALL affect no timing, latency or handshake behaviour.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- start with kernel_len=3, three contiguous taps, accum_in=384 at the sample cycle -> out_data=2, done 4 cycles after the last tap.
- accum_in=-384 -> out_data=-1; accum_in=2^30 -> out_data=32767; accum_in=-2^30 -> out_data=-32768 (0 with MACC_DRAIN_RELU_EN).
- kernel_len=0 with one tap -> result captured; taps spread with idle gaps and a start during WAIT -> the extra start is ignored and counts are correct.
- out_ready=0, five kernels run -> four entries held, overflow=1 after the fifth; then drain -> four values in order, out_valid=0.
- FIFO full, fifth push coincides with out_ready=1 -> no overflow, occupancy stays 4, order preserved.
- rst asserted in WAIT -> no done pulse, out_valid=0, busy=0 next cycle; a new kernel then completes normally.
